// File: rtl/rem3_pkg.sv
// rem3_pkg: shared constants, state names and remainder-update helper for rem3.
package rem3_pkg;
  localparam int DEFAULT_DIVISOR = 3;
  typedef enum logic [1:0] {R0, R1, R2} rem3_state_e;
  function automatic int rem_width(input int d);
    return (d <= 2) ? 1 : $clog2(d);
  endfunction
  // Out-of-range states fold back to 0 so a corrupted register self-recovers.
  function automatic int next_rem(input int r, input int x, input int divisor);
    int t;
    if (r >= divisor) return 0;
    t = 2 * r + x;
    return (t >= divisor) ? t - divisor : t;
  endfunction
endpackage

// File: rtl/rem3.sv
// rem3: bit-serial MSB-first divisibility detector, Moore outputs from remainder state.
module rem3 import rem3_pkg::*; #(
  parameter int DIVISOR = DEFAULT_DIVISOR,
  localparam int RW = rem_width(DIVISOR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x,
  output logic          out,
  output logic [RW-1:0] remainder
);
  logic [RW-1:0] r_rem;
  logic [RW-1:0] w_next;
  always_comb begin
    w_next    = RW'(next_rem(int'(r_rem), int'(x), DIVISOR));
    out       = (r_rem == '0);
    remainder = r_rem;
  end
  always_ff @(posedge clk)
    r_rem <= rst ? '0 : w_next;
  a_rem_range: assert property (@(posedge clk) disable iff (rst) int'(r_rem) < DIVISOR);
endmodule

// File: tb/tb_rem3.sv
// tb_rem3: scoreboard bench driving one serial stream into DIVISOR=3/5/4 instances.
module tb_rem3;
  import rem3_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic x = 1'b0;
  logic o3, o5, o4;
  logic [1:0] r3;
  logic [2:0] r5;
  logic [1:0] r4;
  typedef struct {string nm; int e3; int e5; int e4;} exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  int m3 = 0, m5 = 0, m4 = 0;
  rem3 #(.DIVISOR(3)) u3 (.clk(clk), .rst(rst), .x(x), .out(o3), .remainder(r3));
  rem3 #(.DIVISOR(5)) u5 (.clk(clk), .rst(rst), .x(x), .out(o5), .remainder(r5));
  rem3 #(.DIVISOR(4)) u4 (.clk(clk), .rst(rst), .x(x), .out(o4), .remainder(r4));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask
  // Monitor: outputs are sampled on the falling edge, half a cycle after the update.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk($sformatf("%s d3 rem", e.nm), int'(r3), e.e3);
      chk($sformatf("%s d3 out", e.nm), int'(o3), int'(e.e3 == 0));
      chk($sformatf("%s d5 rem", e.nm), int'(r5), e.e5);
      chk($sformatf("%s d5 out", e.nm), int'(o5), int'(e.e5 == 0));
      chk($sformatf("%s d4 rem", e.nm), int'(r4), e.e4);
      chk($sformatf("%s d4 out", e.nm), int'(o4), int'(e.e4 == 0));
    end
  end
  // Negative expectations fall back to the independent modulo model.
  task automatic step(input bit rb, input bit xb, input int e3, input int e5, input int e4, input string nm);
    exp_t e;
    @(negedge clk);
    rst = rb;
    x = xb;
    @(posedge clk);
    m3 = rb ? 0 : (2 * m3 + int'(xb)) % 3;
    m5 = rb ? 0 : (2 * m5 + int'(xb)) % 5;
    m4 = rb ? 0 : (2 * m4 + int'(xb)) % 4;
    e.nm = nm;
    e.e3 = (e3 < 0) ? m3 : e3;
    e.e5 = (e5 < 0) ? m5 : e5;
    e.e4 = (e4 < 0) ? m4 : e4;
    q.push_back(e);
  endtask
  // rst, x, expected remainder for DIVISOR 3, 5, 4
  int vec [20][5] = '{
    '{1, 0, 0, 0, 0},
    '{1, 0, 0, 0, 0},
    '{1, 1, 0, 0, 0},
    '{0, 1, 1, 1, 1},
    '{0, 1, 0, 3, 3},
    '{0, 0, 0, 1, 2},
    '{0, 0, 0, 2, 0},
    '{1, 0, 0, 0, 0},
    '{0, 1, 1, 1, 1},
    '{0, 0, 2, 2, 2},
    '{0, 1, 2, 0, 1},
    '{0, 0, 1, 0, 2},
    '{0, 1, 0, 1, 1},
    '{1, 1, 0, 0, 0},
    '{0, 1, 1, 1, 1},
    '{0, 0, 2, 2, 2},
    '{1, 0, 0, 0, 0},
    '{0, 1, 1, 1, 1},
    '{1, 1, 0, 0, 0},
    '{0, 1, 1, 1, 1}
  };
  initial begin
    for (int i = 0; i < 20; i++)
      step(vec[i][0] != 0, vec[i][1] != 0, vec[i][2], vec[i][3], vec[i][4], $sformatf("dir%0d", i));
    for (int i = 0; i < 1000; i++)
      step($urandom_range(49) == 0, $urandom_range(1) != 0, -1, -1, -1, $sformatf("rnd%0d", i));
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) chk("drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
